acumulador_sumas: RTL and testbench

ACUMULADOR_SUMAS -- requirements
Module: acumulador_sumas

---
 rtl/acumulador_sumas_if.sv | 24 ++
 rtl/acumulador_sumas.sv | 96 +++++++++
 tb/tb_acumulador_sumas.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_sumas_if.sv
// rtl/acumulador_sumas_if.sv - sample, clear, read and status signals of the accumulator
`timescale 1ns/1ps
interface acumulador_sumas_if;
  logic       valid_in;
  logic [3:0] sum_in;
  logic [3:0] idx_in;
  logic       clr;
  logic       rd_req;
  logic [1:0] rd_idx;
  logic [7:0] acc_out;
  logic       acc_valid;
  logic [3:0] ovf;
  logic [7:0] sample_cnt;

  modport master (
    output valid_in, sum_in, idx_in, clr, rd_req, rd_idx,
    input  acc_out, acc_valid, ovf, sample_cnt
  );

  modport slave (
    input  valid_in, sum_in, idx_in, clr, rd_req, rd_idx,
    output acc_out, acc_valid, ovf, sample_cnt
  );
endinterface

// File: rtl/acumulador_sumas.sv
// rtl/acumulador_sumas.sv - four 8-bit bins fed by a two-stage sample pipeline with bypassed reads
// Build option ACUM_SATURATE_EN: overflowing bins saturate at 8'hFF instead of wrapping.
`timescale 1ns/1ps
module acumulador_sumas (
  input logic               clk,
  input logic               reset_L,
  acumulador_sumas_if.slave bus
);

  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      s1_sum_q, s1_sum_d;
  logic [1:0]      s1_idx_q, s1_idx_d;
  logic [3:0][7:0] bin_q, bin_d;
  logic [3:0]      ovf_q, ovf_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      acc_out_q, acc_out_d;
  logic            acc_valid_q, acc_valid_d;

  logic [8:0]      sum9;
  logic [7:0]      upd_val;
  logic            unused_idx_hi;

  assign unused_idx_hi = ^bus.idx_in[3:2];

  assign sum9 = {1'b0, bin_q[s1_idx_q]} + {5'b0, s1_sum_q};

`ifdef ACUM_SATURATE_EN
  assign upd_val = sum9[8] ? 8'hFF : sum9[7:0];
`else
  assign upd_val = sum9[7:0];
`endif

  always_comb begin
    s1_valid_d = bus.valid_in;
    s1_sum_d   = s1_sum_q;
    s1_idx_d   = s1_idx_q;
    if (bus.valid_in) begin
      s1_sum_d = bus.sum_in;
      s1_idx_d = bus.idx_in[1:0];
    end
  end

  // clr discards the S2 commit at the same edge, including its count
  always_comb begin
    bin_d = bin_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (bus.clr) begin
      bin_d = '0;
      ovf_d = '0;
    end else if (s1_valid_q) begin
      bin_d[s1_idx_q] = upd_val;
      cnt_d           = cnt_q + 8'd1;
      if (sum9[8]) begin
        ovf_d[s1_idx_q] = 1'b1;
      end
    end
  end

  // Reads take next-state bins so a same-edge update or clear is visible
  always_comb begin
    acc_out_d   = acc_out_q;
    acc_valid_d = bus.rd_req;
    if (bus.rd_req) begin
      acc_out_d = bin_d[bus.rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_idx_q    <= '0;
      bin_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_idx_q    <= s1_idx_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.acc_out    = acc_out_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_acumulador_sumas.sv
// tb/tb_acumulador_sumas.sv - randomized and directed checks of acumulador_sumas against a behavioural model
`timescale 1ns/1ps
module tb_acumulador_sumas;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  acumulador_sumas_if bus();

  acumulador_sumas dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int m_bin[4];
  int m_ovf = 0;
  int m_cnt = 0;
  bit m_pv = 0;
  int m_ps = 0;
  int m_pi = 0;
  int m_acc = 0;
  bit m_accv = 0;

`ifdef ACUM_SATURATE_EN
  localparam int EXP_BIN2_18X15 = 255;
`else
  localparam int EXP_BIN2_18X15 = 14;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bins as plain integers; a sample taken at one edge is added at the next
  always @(posedge clk or negedge reset_L) begin
    int s;
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) m_bin[i] = 0;
      m_ovf = 0; m_cnt = 0; m_pv = 0; m_ps = 0; m_pi = 0; m_acc = 0; m_accv = 0;
    end else begin
      if (bus.clr) begin
        for (int i = 0; i < 4; i++) m_bin[i] = 0;
        m_ovf = 0;
      end else if (m_pv) begin
        s = m_bin[m_pi] + m_ps;
        if (s > 255) m_ovf = m_ovf | (1 << m_pi);
`ifdef ACUM_SATURATE_EN
        m_bin[m_pi] = (s > 255) ? 255 : s;
`else
        m_bin[m_pi] = s % 256;
`endif
        m_cnt = (m_cnt + 1) % 256;
      end
      m_accv = bus.rd_req;
      if (bus.rd_req) m_acc = m_bin[int'(bus.rd_idx)];
      m_pv = bus.valid_in;
      if (bus.valid_in) begin
        m_ps = int'(bus.sum_in);
        m_pi = int'(bus.idx_in) % 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("acc_valid", {31'b0, bus.acc_valid}, m_accv);
    chk("acc_out", {24'b0, bus.acc_out}, m_acc);
    chk("ovf", {28'b0, bus.ovf}, m_ovf);
    chk("sample_cnt", {24'b0, bus.sample_cnt}, m_cnt);
  end

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.sum_in   = '0;
    bus.idx_in   = '0;
    bus.clr      = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_idx   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #1 reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    chk("reset acc_out", {24'b0, bus.acc_out}, 0);
    chk("reset acc_valid", {31'b0, bus.acc_valid}, 0);
    chk("reset ovf", {28'b0, bus.ovf}, 0);
    chk("reset sample_cnt", {24'b0, bus.sample_cnt}, 0);

    // 3+5+7 into bin1
    bus.valid_in = 1'b1; bus.idx_in = 4'd1; bus.sum_in = 4'd3; tick();
    bus.sum_in = 4'd5; tick();
    bus.sum_in = 4'd7; tick();
    idle(); tick();
    chk("seq cnt", {24'b0, bus.sample_cnt}, 3);
    bus.rd_req = 1'b1; bus.rd_idx = 2'd1; tick();
    chk("seq acc_valid", {31'b0, bus.acc_valid}, 1);
    chk("seq acc_out", {24'b0, bus.acc_out}, 15);
    idle(); tick();
    chk("seq acc_valid drop", {31'b0, bus.acc_valid}, 0);
    chk("seq acc_out hold", {24'b0, bus.acc_out}, 15);

    // 18 x 15 into bin2 overflows
    do_reset();
    bus.valid_in = 1'b1; bus.idx_in = 4'd2; bus.sum_in = 4'd15;
    repeat (18) tick();
    idle(); tick();
    bus.rd_req = 1'b1; bus.rd_idx = 2'd2; tick();
    chk("ovf bin2", {28'b0, bus.ovf}, 4'b0100);
    chk("ovf acc_out", {24'b0, bus.acc_out}, EXP_BIN2_18X15);
    chk("ovf cnt", {24'b0, bus.sample_cnt}, 18);

    // upper idx bits ignored, same-edge read bypass
    do_reset();
    bus.valid_in = 1'b1; bus.idx_in = 4'b1110; bus.sum_in = 4'd9; tick();
    idle(); bus.rd_req = 1'b1; bus.rd_idx = 2'd2; tick();
    chk("bypass acc_valid", {31'b0, bus.acc_valid}, 1);
    chk("bypass acc_out", {24'b0, bus.acc_out}, 9);

    // clr wins over a same-edge commit; sample with clr survives
    do_reset();
    bus.valid_in = 1'b1; bus.idx_in = 4'd0; bus.sum_in = 4'd6; tick();
    bus.sum_in = 4'd4; bus.clr = 1'b1; bus.rd_req = 1'b1; bus.rd_idx = 2'd0; tick();
    chk("clr read", {24'b0, bus.acc_out}, 0);
    chk("clr cnt", {24'b0, bus.sample_cnt}, 0);
    idle(); tick();
    bus.rd_req = 1'b1; bus.rd_idx = 2'd0; tick();
    chk("clr bin0", {24'b0, bus.acc_out}, 4);
    chk("clr ovf", {28'b0, bus.ovf}, 0);
    chk("clr cnt after", {24'b0, bus.sample_cnt}, 1);

    // sample_cnt wraps after 256 commits
    do_reset();
    repeat (256) begin
      bus.valid_in = 1'b1;
      bus.sum_in = 4'($urandom_range(0, 15));
      bus.idx_in = 4'($urandom_range(0, 15));
      tick();
    end
    chk("cnt 255", {24'b0, bus.sample_cnt}, 255);
    idle(); tick();
    chk("cnt wrap", {24'b0, bus.sample_cnt}, 0);

    // random traffic, checked every cycle by the model
    do_reset();
    repeat (3000) begin
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.sum_in   = 4'($urandom_range(0, 15));
      bus.idx_in   = 4'($urandom_range(0, 15));
      bus.clr      = ($urandom_range(0, 63) == 0);
      bus.rd_req   = ($urandom_range(0, 2) == 0);
      bus.rd_idx   = 2'($urandom_range(0, 3));
      tick();
    end

    // asynchronous reset with a sample in flight
    do_reset();
    bus.valid_in = 1'b1; bus.idx_in = 4'd3; bus.sum_in = 4'd5;
    bus.rd_req = 1'b1; bus.rd_idx = 2'd3;
    repeat (4) tick();
    #2 reset_L = 1'b0;
    #1;
    chk("async acc_out", {24'b0, bus.acc_out}, 0);
    chk("async acc_valid", {31'b0, bus.acc_valid}, 0);
    chk("async ovf", {28'b0, bus.ovf}, 0);
    chk("async sample_cnt", {24'b0, bus.sample_cnt}, 0);
    idle();
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    tick();
    chk("post reset cnt", {24'b0, bus.sample_cnt}, 0);
    bus.rd_req = 1'b1; bus.rd_idx = 2'd3; tick();
    chk("post reset bin3", {24'b0, bus.acc_out}, 0);
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
